// File: rtl/arb_req_agent.sv
// Requester-side agent for one port of the 4-way request/grant arbiter.
// Define ARB_REQ_TIMEOUT_EN to build the ungranted-request abandon path (wait counter, err_timeout_o).
module arb_req_agent #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    output logic             cmd_ready_o,
    output logic             req_o,
    input  logic             gnt_i,
    output logic             beat_o,
    output logic             done_o,
    output logic             err_timeout_o,
    output logic             err_lost_o
);

    // state  | meaning
    // S_IDLE | ready for a command, req low
    // S_REQ  | req high, waiting for gnt
    // S_XFER | granted, one beat per cycle
    // S_REL  | req low, waiting for gnt to drop
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             err_lost_q, err_lost_d;

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_timeout_q, err_timeout_d;
`endif

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        err_lost_d = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        err_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    beat_cnt_d = cmd_len_i;
`ifdef ARB_REQ_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // A grant sampled on the same edge as the timeout wins.
                if (gnt_i) begin
                    state_d = S_XFER;
                end else begin
`ifdef ARB_REQ_TIMEOUT_EN
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_q >= WAIT_LAST) begin
                        state_d       = S_REL;
                        err_timeout_d = 1'b1;
                    end
`endif
                end
            end
            S_XFER: begin
                if (!gnt_i) begin
                    state_d    = S_REL;
                    err_lost_d = 1'b1;
                end else if (beat_cnt_q == '0) begin
                    state_d = S_REL;
                    done_d  = 1'b1;
                end else begin
                    beat_cnt_d = beat_cnt_q - 1'b1;
                end
            end
            S_REL: begin
                if (!gnt_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d = (state_d == S_REQ) || (state_d == S_XFER);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            err_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            req_q      <= req_d;
            done_q     <= done_d;
            err_lost_q <= err_lost_d;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign err_timeout_o = err_timeout_q;
`else
    assign err_timeout_o = 1'b0;
`endif

    assign cmd_ready_o = (state_q == S_IDLE);
    assign beat_o      = (state_q == S_XFER);
    assign req_o       = req_q;
    assign done_o      = done_q;
    assign err_lost_o  = err_lost_q;

endmodule
